uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
// - Transmit half of the UART. Pops bytes from the TX FIFO (same FIFO block and
//   pop handshake as the RX path) and serialises each one onto Tx as a frame:
//   start bit, data bits LSB first, optional parity bit, then 1 or 2 stop bits.
// - Sits between the TX FIFO's Data_Out/FIFO_Empty/Pop_Data and the pad.
// PARAMETERS
// - DATA_BITS    8   data bits per frame (5..9)
// - CLKS_PER_BIT 16  clk cycles per bit period (>=2)
// - PARITY_MODE  0   0=none, 1=even, 2=odd; 3 is an elaboration $error
// - STOP_BITS    1   1 or 2; any other value is an elaboration $error
// PORTS
// - clk        in   1          system clock, all state on posedge
// - rst        in   1          asynchronous reset, active-high
// - Tx_Data    in   DATA_BITS  byte from FIFO Data_Out, valid the cycle after Pop_Data
// - FIFO_Empty in   1          1 = no byte available
// - BIST_Mode  in   1          1 = start no new frame
// - Pop_Data   out  1          one-cycle pop strobe to the FIFO
// - Tx         out  1          serial line, idle high
// - Tx_Busy    out  1          1 whenever state != IDLE
// - Tx_Done    out  1          one-cycle pulse in the final stop-bit clock
// BEHAVIOUR
// - Reset (async, immediate): Tx=1, Pop_Data=0, Tx_Busy=0, Tx_Done=0, state=IDLE,
//   counters=0. The frame in flight is dropped and the byte is not re-popped.
// - All outputs are registered. Each output changes on the clock edge that enters
//   the state or bit period that drives it.
// - FSM: IDLE -> POP -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE
//   - IDLE: Tx=1. If FIFO_Empty==0 && BIST_Mode==0 then go to POP, else stay.
//   - POP: Pop_Data=1 for exactly one cycle, then go to LOAD.
//   - LOAD: shift register and running parity <= Tx_Data, then go to START.
//   - START: Tx=0 for CLKS_PER_BIT clocks.
//   - DATA: DATA_BITS periods, bit 0 first. The bit counter counts 0..DATA_BITS-1.
//   - PARITY: skipped when PARITY_MODE=0. Even: the parity bit makes the count of
//     ones in data+parity even. Odd: the count is odd.
//   - STOP: Tx=1 for STOP_BITS*CLKS_PER_BIT clocks. Tx_Done=1 in the last of these
//     clocks, then go to IDLE.
// - Baud counter: width $clog2(CLKS_PER_BIT). It runs 0..CLKS_PER_BIT-1, wraps to
//   0 on each bit boundary, and is cleared on entry to START.
// - Latency: IDLE samples FIFO_Empty=0 at cycle t. Then Pop_Data=1 at t+1, Tx_Data
//   is latched at t+2, and Tx falls at t+3.
// - Frame length, START entry to STOP exit:
//   (1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS) * CLKS_PER_BIT clocks.
// - Back-to-back frames: Tx_Done at cycle n, IDLE at n+1, POP at n+2, start bit at
//   n+4. This gives 3 extra idle-high clocks between frames.
// - BIST_Mode is sampled only in IDLE. A frame already started always completes.
// - FIFO_Empty and Tx_Data are ignored outside IDLE and LOAD respectively.
//   Pop_Data is never asserted while FIFO_Empty=1.
// TESTING
// - Params 8/4/0/1, push 8'hA5: exactly 1 Pop_Data pulse. Tx bits
//   0,1,0,1,0,0,1,0,1,1, each 4 clocks (40 clocks total). Tx_Done in clock 40.
// - PARITY_MODE=1, byte 8'h07: parity bit 1. PARITY_MODE=2, same byte: parity bit
//   0. Frame is 44 clocks.
// - Push 8'h55 then 8'hC3: 2 Pop_Data pulses. Tx high for 3 clocks past the first
//   stop period before the second start bit. Second frame bits correct.
// - BIST_Mode=1 with FIFO non-empty: no Pop_Data, Tx=1, Tx_Busy=0. Raising
//   BIST_Mode mid-frame: the frame still completes with Tx_Done.
// - Assert rst during data bit 3: Tx=1 and Tx_Busy=0 with no clock edge. After
//   release with FIFO_Empty=1: no Pop_Data and Tx stays high.
// - STOP_BITS=2, CLKS_PER_BIT=4: stop high for 8 clocks. Tx_Done only in the 8th
//   of those clocks.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: pops one byte per frame from the TX FIFO and shifts it
// out as start bit, LSB-first data, optional parity and 1 or 2 stop bits.
// Every output is a flop loaded on the edge that enters the state driving it.
module uart_tx #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] Tx_Data,
    input  logic                 FIFO_Empty,
    input  logic                 BIST_Mode,
    output logic                 Pop_Data,
    output logic                 Tx,
    output logic                 Tx_Busy,
    output logic                 Tx_Done
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitW = $clog2(DATA_BITS);

    localparam logic [CntW-1:0] CntLast    = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntPreLast = CntW'(CLKS_PER_BIT - 2);
    localparam logic [BitW-1:0] BitLast    = BitW'(DATA_BITS - 1);
    localparam logic [BitW-1:0] StopLast   = BitW'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : gen_bad_data_bits
        $error("uart_tx: DATA_BITS must be in 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : gen_bad_clks_per_bit
        $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if (PARITY_MODE > 2) begin : gen_bad_parity_mode
        $error("uart_tx: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        StIdle, StPop, StLoad, StStart, StData, StParity, StStop
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [BitW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic                   pop_q, pop_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   bit_end;

    // Last clock of the current bit period.
    assign bit_end = (cnt_q == CntLast);

    // State register; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; BIST_Mode and FIFO_Empty only matter in idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (!FIFO_Empty && !BIST_Mode) state_d = StPop;
            StPop:    state_d = StLoad;
            StLoad:   state_d = StStart;
            StStart:  if (bit_end) state_d = StData;
            StData: begin
                if (bit_end && bit_q == BitLast) begin
                    state_d = (PARITY_MODE != 0) ? StParity : StStop;
                end
            end
            StParity: if (bit_end) state_d = StStop;
            StStop:   if (bit_end && bit_q == StopLast) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Baud/bit counters and shift register; counters idle at zero so START
    // always begins with a fresh baud count.
    always_comb begin
        cnt_d   = '0;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        if (state_q inside {StStart, StData, StParity, StStop}) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end
        unique case (state_q)
            StLoad: begin
                shift_d = Tx_Data;
                par_d   = ^Tx_Data;
                bit_d   = '0;
            end
            StData: begin
                if (bit_end) begin
                    if (bit_q == BitLast) begin
                        bit_d = '0;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            // In STOP the bit counter indexes the stop bit.
            StStop: begin
                if (bit_end) bit_d = (bit_q == StopLast) ? '0 : bit_q + 1'b1;
            end
            StIdle:  bit_d = '0;
            default: ;
        endcase
    end

    // Output next values, derived from the state being entered.
    always_comb begin
        pop_d  = (state_d == StPop);
        busy_d = (state_d != StIdle);
        // Registered, so raised one clock ahead of the final stop clock.
        done_d = (state_q == StStop) && (bit_q == StopLast) && (cnt_q == CntPreLast);
        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = (PARITY_MODE == 2) ? ~par_q : par_q;
            default:  tx_d = 1'b1;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            pop_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            pop_q   <= pop_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Pop_Data = pop_q;
    assign Tx       = tx_q;
    assign Tx_Busy  = busy_q;
    assign Tx_Done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no parity/1 stop, even/1 stop,
// odd/2 stop) fed from a FIFO model; traces compared to a frame model.
module tb_uart_tx;

    localparam int NumInst = 3;
    localparam int Clks    = 4;
    localparam int MaxCyc  = 512;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] txd  [NumInst];
    logic       emp  [NumInst];
    logic       bist [NumInst];
    logic       pop  [NumInst];
    logic       tx   [NumInst];
    logic       busy [NumInst];
    logic       done [NumInst];

    int cfg_par  [NumInst] = '{0, 1, 2};
    int cfg_stop [NumInst] = '{1, 1, 2};

    uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(Clks), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .Tx_Data(txd[0]), .FIFO_Empty(emp[0]), .BIST_Mode(bist[0]),
        .Pop_Data(pop[0]), .Tx(tx[0]), .Tx_Busy(busy[0]), .Tx_Done(done[0])
    );
    uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(Clks), .PARITY_MODE(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .Tx_Data(txd[1]), .FIFO_Empty(emp[1]), .BIST_Mode(bist[1]),
        .Pop_Data(pop[1]), .Tx(tx[1]), .Tx_Busy(busy[1]), .Tx_Done(done[1])
    );
    uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(Clks), .PARITY_MODE(2), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .Tx_Data(txd[2]), .FIFO_Empty(emp[2]), .BIST_Mode(bist[2]),
        .Pop_Data(pop[2]), .Tx(tx[2]), .Tx_Busy(busy[2]), .Tx_Done(done[2])
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         sel   = 0;
    int         cyc   = 0;
    int         stray = 0;
    int         underflow = 0;
    logic [7:0] fifo [$];
    logic [7:0] sent [$];
    logic       load_pend  = 1'b0;
    logic       scrub_pend = 1'b0;
    logic [7:0] load_byte  = 8'h00;

    logic tr_tx [MaxCyc], tr_pop [MaxCyc], tr_busy [MaxCyc], tr_done [MaxCyc];
    logic ex_tx [MaxCyc], ex_pop [MaxCyc], ex_busy [MaxCyc], ex_done [MaxCyc];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic set_empty();
        for (int i = 0; i < NumInst; i++) emp[i] = !((i == sel) && (fifo.size() != 0));
    endtask

    // One clock: FIFO model reacts to pops, then the selected DUT is sampled.
    task automatic step();
        @(posedge clk);
        #1;
        if (load_pend) begin
            txd[sel]   = load_byte;
            load_pend  = 1'b0;
            scrub_pend = 1'b1;
        end else if (scrub_pend) begin
            txd[sel]   = 8'($urandom);
            scrub_pend = 1'b0;
        end
        if (pop[sel] === 1'b1) begin
            if (fifo.size() == 0) underflow++;
            else load_byte = fifo.pop_front();
            load_pend = 1'b1;
        end
        for (int i = 0; i < NumInst; i++) if (i != sel && pop[i] !== 1'b0) stray++;
        set_empty();
        if (cyc < MaxCyc) begin
            tr_tx[cyc]   = tx[sel];
            tr_pop[cyc]  = pop[sel];
            tr_busy[cyc] = busy[sel];
            tr_done[cyc] = done[sel];
        end
        cyc++;
    endtask

    task automatic run(input int n);
        set_empty();
        cyc = 0;
        for (int k = 0; k < n; k++) step();
    endtask

    function automatic int frame_len(input int inst);
        return (1 + 8 + ((cfg_par[inst] != 0) ? 1 : 0) + cfg_stop[inst]) * Clks;
    endfunction

    // Frame model: bytes queued before cycle 0 go out back to back, each frame
    // occupying frame_len+3 clocks (pop, load, frame, one idle sample clock).
    task automatic build_exp(input int inst, input logic [7:0] bytes [$], input int n);
        int   flen;
        int   nbit;
        int   base;
        int   ones;
        int   idx;
        logic seq [12];
        flen = frame_len(inst);
        nbit = flen / Clks;
        for (int k = 0; k < MaxCyc; k++) begin
            ex_tx[k] = 1'b1; ex_pop[k] = 1'b0; ex_busy[k] = 1'b0; ex_done[k] = 1'b0;
        end
        for (int f = 0; f < bytes.size(); f++) begin
            base = f * (flen + 3);
            ones = 0;
            seq[0] = 1'b0;
            for (int b = 0; b < 8; b++) begin
                seq[1 + b] = bytes[f][b];
                ones += int'(bytes[f][b]);
            end
            idx = 9;
            if (cfg_par[inst] != 0) begin
                seq[9] = (cfg_par[inst] == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
                idx = 10;
            end
            for (int s = 0; s < cfg_stop[inst]; s++) seq[idx + s] = 1'b1;
            if (base + flen + 1 < n) begin
                ex_pop[base] = 1'b1;
                for (int t = base; t <= base + flen + 1; t++) ex_busy[t] = 1'b1;
                for (int b = 0; b < nbit; b++)
                    for (int c = 0; c < Clks; c++) ex_tx[base + 2 + b * Clks + c] = seq[b];
                ex_done[base + flen + 1] = 1'b1;
            end
        end
    endtask

    task automatic report(input string name, input int first, input logic got, input logic want);
        total++;
        if (first >= 0) begin
            bad++;
            $display("FAIL %s: cycle %0d got %b want %b", name, first, got, want);
        end
    endtask

    task automatic cmp_trace(input string name, input int n);
        int ft, fp, fb, fd;
        ft = -1; fp = -1; fb = -1; fd = -1;
        for (int k = n - 1; k >= 0; k--) begin
            if (tr_tx[k]   !== ex_tx[k])   ft = k;
            if (tr_pop[k]  !== ex_pop[k])  fp = k;
            if (tr_busy[k] !== ex_busy[k]) fb = k;
            if (tr_done[k] !== ex_done[k]) fd = k;
        end
        report({name, " Tx"},       ft, (ft >= 0) ? tr_tx[ft]   : 1'b0, (ft >= 0) ? ex_tx[ft]   : 1'b0);
        report({name, " Pop_Data"}, fp, (fp >= 0) ? tr_pop[fp]  : 1'b0, (fp >= 0) ? ex_pop[fp]  : 1'b0);
        report({name, " Tx_Busy"},  fb, (fb >= 0) ? tr_busy[fb] : 1'b0, (fb >= 0) ? ex_busy[fb] : 1'b0);
        report({name, " Tx_Done"},  fd, (fd >= 0) ? tr_done[fd] : 1'b0, (fd >= 0) ? ex_done[fd] : 1'b0);
    endtask

    typedef struct {
        int         inst;
        logic [7:0] data;
        int         nbits;
        logic [11:0] bits;  // bit i = i-th transmitted bit (start first)
    } vec_t;

    initial begin : main
        vec_t       vecs [6];
        vec_t       v;
        int         n, npop, fpop, nbad, ndone, fdone, inst, nb;
        logic [7:0] rb;

        vecs[0] = '{0, 8'hA5, 10, {2'b00, 1'b1, 8'hA5, 1'b0}};
        vecs[1] = '{0, 8'h3C, 10, {2'b00, 1'b1, 8'h3C, 1'b0}};
        vecs[2] = '{1, 8'h07, 11, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}};
        vecs[3] = '{1, 8'h00, 11, {1'b0, 1'b1, 1'b0, 8'h00, 1'b0}};
        vecs[4] = '{2, 8'h07, 12, {1'b1, 1'b1, 1'b0, 8'h07, 1'b0}};
        vecs[5] = '{2, 8'hFF, 12, {1'b1, 1'b1, 1'b1, 8'hFF, 1'b0}};

        for (int i = 0; i < NumInst; i++) begin
            txd[i] = 8'h00; emp[i] = 1'b1; bist[i] = 1'b0;
        end
        #1 rst = 1'b1;
        #2;
        for (int i = 0; i < NumInst; i++) begin
            check($sformatf("reset u%0d Tx", i),       int'(tx[i]),   1);
            check($sformatf("reset u%0d Pop_Data", i), int'(pop[i]),  0);
            check($sformatf("reset u%0d Tx_Busy", i),  int'(busy[i]), 0);
            check($sformatf("reset u%0d Tx_Done", i),  int'(done[i]), 0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed frames from the vector table.
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            sel = v.inst;
            fifo.push_back(v.data);
            n = v.nbits * Clks + 8;
            run(n);
            npop = 0; fpop = -1; ndone = 0; fdone = -1; nbad = 0;
            for (int k = 0; k < n; k++) begin
                if (tr_pop[k] === 1'b1) begin npop++; if (fpop < 0) fpop = k; end
                if (tr_done[k] === 1'b1) begin ndone++; if (fdone < 0) fdone = k; end
            end
            for (int b = 0; b < v.nbits; b++)
                for (int c = 0; c < Clks; c++)
                    if (tr_tx[2 + b * Clks + c] !== v.bits[b]) nbad++;
            check($sformatf("v%0d pop count", i), npop, 1);
            check($sformatf("v%0d pop cycle", i), fpop, 0);
            check($sformatf("v%0d pre-start high", i), int'(tr_tx[0] & tr_tx[1]), 1);
            check($sformatf("v%0d frame bit errors", i), nbad, 0);
            check($sformatf("v%0d done count", i), ndone, 1);
            check($sformatf("v%0d done cycle", i), fdone, 1 + v.nbits * Clks);
            check($sformatf("v%0d busy last stop", i), int'(tr_busy[1 + v.nbits * Clks]), 1);
            check($sformatf("v%0d busy after", i), int'(tr_busy[2 + v.nbits * Clks]), 0);
            check($sformatf("v%0d line after", i), int'(tr_tx[2 + v.nbits * Clks]), 1);
        end

        // Back-to-back 55 then C3: 3 idle-high clocks between frames.
        sel = 0;
        fifo.push_back(8'h55);
        fifo.push_back(8'hC3);
        run(92);
        npop = 0; ndone = 0; nbad = 0;
        for (int k = 0; k < 92; k++) begin
            if (tr_pop[k] === 1'b1) npop++;
            if (tr_done[k] === 1'b1) ndone++;
        end
        check("b2b pop count", npop, 2);
        check("b2b second pop cycle", int'(tr_pop[43]), 1);
        check("b2b gap high", int'(tr_tx[42] & tr_tx[43] & tr_tx[44]), 1);
        check("b2b second start", int'(tr_tx[45]), 0);
        rb = 8'hC3;
        for (int b = 0; b < 8; b++)
            for (int c = 0; c < Clks; c++)
                if (tr_tx[49 + b * Clks + c] !== rb[b]) nbad++;
        check("b2b second data bit errors", nbad, 0);
        check("b2b done count", ndone, 2);

        // BIST held with a byte waiting: nothing happens, then release.
        sel = 0;
        bist[0] = 1'b1;
        fifo.push_back(8'h5A);
        run(20);
        sent.delete();
        build_exp(0, sent, 20);
        cmp_trace("bist hold", 20);
        bist[0] = 1'b0;
        run(48);
        sent.push_back(8'h5A);
        build_exp(0, sent, 48);
        cmp_trace("bist release", 48);

        // BIST raised mid-frame: frame finishes, next byte stays queued.
        fifo.push_back(8'h96);
        fifo.push_back(8'h69);
        set_empty();
        cyc = 0;
        for (int k = 0; k < 10; k++) step();
        bist[0] = 1'b1;
        for (int k = 0; k < 60; k++) step();
        sent.delete();
        sent.push_back(8'h96);
        build_exp(0, sent, 70);
        cmp_trace("bist mid-frame", 70);
        check("bist mid-frame bytes left", fifo.size(), 1);
        bist[0] = 1'b0;
        run(48);
        sent.delete();
        sent.push_back(8'h69);
        build_exp(0, sent, 48);
        cmp_trace("bist drain", 48);

        // Reset during data bit 3 of A5 (a zero bit).
        sel = 0;
        fifo.push_back(8'hA5);
        set_empty();
        cyc = 0;
        for (int k = 0; k < 20; k++) step();
        check("pre-reset data bit 3", int'(tx[0]), 0);
        check("pre-reset busy", int'(busy[0]), 1);
        #2 rst = 1'b1;
        #1;
        check("async reset Tx", int'(tx[0]), 1);
        check("async reset Tx_Busy", int'(busy[0]), 0);
        fifo.delete();
        load_pend = 1'b0;
        scrub_pend = 1'b0;
        set_empty();
        step();
        step();
        #2 rst = 1'b0;
        run(20);
        sent.delete();
        build_exp(0, sent, 20);
        cmp_trace("after reset", 20);

        // Random bursts against the frame model.
        for (int it = 0; it < 6; it++) begin
            inst = int'($urandom_range(0, NumInst - 1));
            nb = int'($urandom_range(1, 4));
            sel = inst;
            sent.delete();
            for (int b = 0; b < nb; b++) begin
                rb = 8'($urandom);
                sent.push_back(rb);
                fifo.push_back(rb);
            end
            n = nb * (frame_len(inst) + 3) + 6;
            run(n);
            build_exp(inst, sent, n);
            cmp_trace($sformatf("rand%0d u%0d", it, inst), n);
        end

        check("pops on idle instances", stray, 0);
        check("pops with FIFO empty", underflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
